// File: rtl/snoop_pkg.sv
// Shared encodings for the snoop bus: bus messages, MSI line states, CPU ops
// and the bus arbiter FSM states.
package snoop_pkg;

    // Bus message encodings
    localparam logic [1:0] MSG_NONE       = 2'd0;
    localparam logic [1:0] MSG_READ_MISS  = 2'd1;
    localparam logic [1:0] MSG_WRITE_MISS = 2'd2;
    localparam logic [1:0] MSG_INVALIDATE = 2'd3;

    // MSI cache line states
    localparam logic [1:0] INVALID  = 2'd0;
    localparam logic [1:0] SHARED   = 2'd1;
    localparam logic [1:0] MODIFIED = 2'd2;

    // CPU operation encodings (read miss/hit, write miss/hit)
    localparam logic [1:0] RM = 2'd0;
    localparam logic [1:0] RH = 2'd1;
    localparam logic [1:0] WM = 2'd2;
    localparam logic [1:0] WH = 2'd3;

    // Bus arbiter FSM states
    typedef enum logic [2:0] {
        StIdle,
        StBcast,
        StSnoop,
        StWb,
        StDone
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from N-1 back to 0.
module rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_Req,
    input  logic [IDX_W-1:0] i_Ptr,
    output logic [N-1:0]     o_OneHot,
    output logic [IDX_W-1:0] o_Idx,
    output logic             o_Valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Scan N candidates starting at the pointer; the first hit wins
    always_comb begin
        o_OneHot = '0;
        o_Idx    = '0;
        o_Valid  = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, i_Ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!o_Valid && i_Req[cand]) begin
                o_Valid        = 1'b1;
                o_OneHot[cand] = 1'b1;
                o_Idx          = cand;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants the shared bus round-robin, broadcasts the winner's
// message, services a single MODIFIED-holder writeback and re-broadcasts once.
module snoop_bus_arbiter
    import snoop_pkg::*;
#(
    parameter int unsigned N_CPUS     = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned WB_TIMEOUT = 15
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [N_CPUS-1:0]     i_Req,
    input  logic [2*N_CPUS-1:0]   i_Msg,
    input  logic [N_CPUS-1:0]     i_Abort,
    input  logic [N_CPUS-1:0]     i_WbDone,
    output logic [N_CPUS-1:0]     o_Grant,
    output logic                  o_BusValid,
    output logic [1:0]            o_BusMsg,
    output logic [IDX_W-1:0]      o_BusSrc,
    output logic [N_CPUS-1:0]     o_WbReq,
    output logic [N_CPUS-1:0]     o_Done,
    output logic                  o_Busy,
    output logic                  o_Error
);

    localparam int unsigned CNT_W = $clog2(WB_TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [N_CPUS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  src_q, src_d;
    logic [1:0]        msg_q, msg_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  wb_tgt_q, wb_tgt_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
    logic              retry_q, retry_d;
    logic              error_q, error_d;

    logic [N_CPUS-1:0] pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [1:0]        pick_msg;

    logic [N_CPUS-1:0] abort_m;
    logic [IDX_W-1:0]  abort_lo_idx;
    logic              abort_any;
    logic              abort_multi;

    rr_picker #(
        .N     (N_CPUS),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .i_Req    (i_Req),
        .i_Ptr    (ptr_q),
        .o_OneHot (pick_onehot),
        .o_Idx    (pick_idx),
        .o_Valid  (pick_valid)
    );

    // Message of the candidate winner
    always_comb begin
        pick_msg = MSG_NONE;
        for (int k = 0; k < N_CPUS; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_msg = i_Msg[2*k +: 2];
            end
        end
    end

    // Snooper aborts, ignoring the requester's own; lowest index is serviced
    always_comb begin
        abort_m      = i_Abort & ~grant_q;
        abort_lo_idx = '0;
        abort_any    = 1'b0;
        for (int k = N_CPUS - 1; k >= 0; k--) begin
            if (abort_m[k]) begin
                abort_lo_idx = IDX_W'(k);
                abort_any    = 1'b1;
            end
        end
        // Two or more MODIFIED holders is an MSI protocol violation
        abort_multi = |(abort_m & (abort_m - {{(N_CPUS - 1){1'b0}}, 1'b1}));
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        src_d    = src_q;
        msg_d    = msg_q;
        ptr_d    = ptr_q;
        wb_tgt_d = wb_tgt_q;
        wb_cnt_d = wb_cnt_q;
        retry_d  = retry_q;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    src_d   = pick_idx;
                    msg_d   = pick_msg;
                    // A NONE message has nothing to broadcast
                    state_d = (pick_msg == MSG_NONE) ? StDone : StBcast;
                end
            end
            StBcast: begin
                state_d = StSnoop;
            end
            StSnoop: begin
                if (abort_any) begin
                    if (abort_multi) begin
                        error_d = 1'b1;
                    end
                    if (retry_q) begin
                        // Line went MODIFIED again after writeback: give up
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        wb_tgt_d = abort_lo_idx;
                        wb_cnt_d = '0;
                        state_d  = StWb;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StWb: begin
                if (i_WbDone[wb_tgt_q]) begin
                    wb_cnt_d = '0;
                    retry_d  = 1'b1;
                    state_d  = StBcast;
                end else if (wb_cnt_q == CNT_W'(WB_TIMEOUT - 1)) begin
                    wb_cnt_d = '0;
                    error_d  = 1'b1;
                    state_d  = StDone;
                end else begin
                    wb_cnt_d = wb_cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                ptr_d   = (src_q == IDX_W'(N_CPUS - 1)) ? '0 : src_q + IDX_W'(1);
                retry_d = 1'b0;
                grant_d = '0;
                src_d   = '0;
                msg_d   = MSG_NONE;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            src_q    <= '0;
            msg_q    <= MSG_NONE;
            ptr_q    <= '0;
            wb_tgt_q <= '0;
            wb_cnt_q <= '0;
            retry_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            src_q    <= src_d;
            msg_q    <= msg_d;
            ptr_q    <= ptr_d;
            wb_tgt_q <= wb_tgt_d;
            wb_cnt_q <= wb_cnt_d;
            retry_q  <= retry_d;
            error_q  <= error_d;
        end
    end

    // Outputs decode directly from state so reset clears them immediately
    always_comb begin
        o_Grant    = grant_q;
        o_BusSrc   = src_q;
        o_BusMsg   = msg_q;
        o_BusValid = (state_q == StBcast);
        o_Busy     = (state_q != StIdle);
        o_Error    = error_q;
        o_WbReq    = '0;
        if (state_q == StWb) begin
            o_WbReq[wb_tgt_q] = 1'b1;
        end
        o_Done = (state_q == StDone) ? grant_q : '0;
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: reset, round-robin order, and a table of single
// transactions checked through a scoreboard of expected completions.
module tb_snoop_bus_arbiter;
    import snoop_pkg::*;

    logic       i_Clock = 1'b0;
    logic       i_Reset;
    logic [3:0] i_Req, i_Abort, i_WbDone;
    logic [7:0] i_Msg;
    logic [3:0] o_Grant, o_WbReq, o_Done;
    logic       o_BusValid, o_Busy, o_Error;
    logic [1:0] o_BusMsg, o_BusSrc;

    always #5 i_Clock = ~i_Clock;

    snoop_bus_arbiter #(
        .N_CPUS     (4),
        .IDX_W      (2),
        .WB_TIMEOUT (15)
    ) dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Req      (i_Req),
        .i_Msg      (i_Msg),
        .i_Abort    (i_Abort),
        .i_WbDone   (i_WbDone),
        .o_Grant    (o_Grant),
        .o_BusValid (o_BusValid),
        .o_BusMsg   (o_BusMsg),
        .o_BusSrc   (o_BusSrc),
        .o_WbReq    (o_WbReq),
        .o_Done     (o_Done),
        .o_Busy     (o_Busy),
        .o_Error    (o_Error)
    );

    // abort: snooper aborts in first SNOOP; abort2: in the re-broadcast SNOOP
    // wb_delay: WB cycle on which the target's i_WbDone fires (0 = never)
    // noise: non-target i_WbDone bits pulse on the first WB cycle
    // lat: samples from first grant-visible cycle to the o_Done cycle
    typedef struct {
        logic [3:0] req;
        logic [7:0] msg;
        logic [3:0] abort;
        logic [3:0] abort2;
        int         wb_delay;
        bit         noise;
        logic [3:0] grant;
        logic [1:0] src;
        logic [1:0] bmsg;
        logic [3:0] wbreq;
        int         nb;
        int         wbc;
        int         lat;
        bit         err;
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic run_vec(input int i);
        vec_t       v, e;
        int         nb, wbc;
        logic [3:0] wbreq_seen;
        bit         prev_valid, done;
        v          = vecs[i];
        i_Req      = v.req;
        i_Msg      = v.msg;
        sb.push_back(v);
        nb         = 0;
        wbc        = 0;
        wbreq_seen = '0;
        prev_valid = 1'b0;
        done       = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            step();
            if (c == 0) chk($sformatf("v%0d grant", i), o_Grant, v.grant);
            // A SNOOP cycle always follows the broadcast cycle
            i_Abort = prev_valid ? ((nb == 1) ? v.abort : v.abort2) : 4'b0000;
            if (o_WbReq != 4'b0000) begin
                wbc++;
                if (wbreq_seen == 4'b0000) wbreq_seen = o_WbReq;
                if (wbc == v.wb_delay)          i_WbDone = v.wbreq;
                else if (v.noise && wbc == 1)   i_WbDone = ~v.wbreq;
                else                            i_WbDone = 4'b0000;
            end else begin
                i_WbDone = 4'b0000;
            end
            if (o_BusValid) nb++;
            prev_valid = o_BusValid;
            if (o_Done != 4'b0000) begin
                done = 1'b1;
                i_Req = 4'b0000;
                e = sb.pop_front();
                chk($sformatf("v%0d done", i), o_Done, e.grant);
                chk($sformatf("v%0d src", i), o_BusSrc, e.src);
                chk($sformatf("v%0d msg", i), o_BusMsg, e.bmsg);
                chk($sformatf("v%0d error", i), o_Error, e.err);
                chk($sformatf("v%0d bcasts", i), nb, e.nb);
                chk($sformatf("v%0d wb cycles", i), wbc, e.wbc);
                chk($sformatf("v%0d wbreq", i), wbreq_seen, e.wbreq);
                chk($sformatf("v%0d latency", i), c, e.lat);
            end
        end
        if (!done) begin
            fail_now($sformatf("v%0d done", i));
            if (sb.size() > 0) void'(sb.pop_front());
        end
        i_Req    = 4'b0000;
        i_Abort  = 4'b0000;
        i_WbDone = 4'b0000;
        step();
        chk($sformatf("v%0d idle", i), {o_Busy, o_Grant}, 5'd0);
    endtask

    initial begin
        logic [3:0] exp_rr[5];
        logic [3:0] prev_g;
        int         ng, last_c;
        bit         d, prev_valid;

        //              req      msg    abort    abort2  dly nz grant    src   bmsg  wbreq   nb wbc lat err
        vecs[0]  = '{4'b0010, 8'h04, 4'b0000, 4'b0000, 0, 0, 4'b0010, 2'd1, 2'd1, 4'b0000, 1, 0,  2, 0};
        vecs[1]  = '{4'b0001, 8'h02, 4'b0100, 4'b0000, 3, 0, 4'b0001, 2'd0, 2'd2, 4'b0100, 2, 3,  7, 0};
        vecs[2]  = '{4'b0010, 8'h0C, 4'b0010, 4'b0000, 0, 0, 4'b0010, 2'd1, 2'd3, 4'b0000, 1, 0,  2, 0};
        vecs[3]  = '{4'b0100, 8'h00, 4'b0000, 4'b0000, 0, 0, 4'b0100, 2'd2, 2'd0, 4'b0000, 0, 0,  0, 0};
        vecs[4]  = '{4'b1001, 8'h41, 4'b0000, 4'b0000, 0, 0, 4'b1000, 2'd3, 2'd1, 4'b0000, 1, 0,  2, 0};
        vecs[5]  = '{4'b1001, 8'h41, 4'b0000, 4'b0000, 0, 0, 4'b0001, 2'd0, 2'd1, 4'b0000, 1, 0,  2, 0};
        vecs[6]  = '{4'b0100, 8'h10, 4'b0001, 4'b0000, 3, 1, 4'b0100, 2'd2, 2'd1, 4'b0001, 2, 3,  7, 0};
        vecs[7]  = '{4'b0001, 8'h02, 4'b0110, 4'b0000, 2, 0, 4'b0001, 2'd0, 2'd2, 4'b0010, 2, 2,  6, 1};
        vecs[8]  = '{4'b0010, 8'h04, 4'b1000, 4'b0000, 0, 0, 4'b0010, 2'd1, 2'd1, 4'b1000, 1, 15, 17, 1};
        vecs[9]  = '{4'b0100, 8'h30, 4'b0001, 4'b0001, 1, 0, 4'b0100, 2'd2, 2'd3, 4'b0001, 2, 1,  5, 1};
        vecs[10] = '{4'b0101, 8'h21, 4'b0000, 4'b0000, 0, 0, 4'b0001, 2'd0, 2'd1, 4'b0000, 1, 0,  2, 1};
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        i_Reset  = 1'b1;
        i_Req    = '0;
        i_Msg    = '0;
        i_Abort  = '0;
        i_WbDone = '0;
        repeat (2) @(posedge i_Clock);
        #1;
        chk("reset outputs", {o_Grant, o_BusValid, o_BusMsg, o_BusSrc, o_WbReq, o_Done, o_Busy,
                              o_Error}, 32'd0);
        i_Reset = 1'b0;
        step();

        // Round robin with all requests held: order and 4-cycle spacing
        i_Req  = 4'hF;
        i_Msg  = 8'h55;
        prev_g = '0;
        ng     = 0;
        last_c = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            step();
            if (o_Grant != 4'b0000 && prev_g == 4'b0000) begin
                chk($sformatf("rr grant %0d", ng), o_Grant, exp_rr[ng]);
                if (ng > 0) chk($sformatf("rr spacing %0d", ng), c - last_c, 4);
                last_c = c;
                ng++;
            end
            prev_g = o_Grant;
        end
        if (ng < 5) fail_now("rr grants");
        i_Req = 4'b0000;
        d = 1'b0;
        for (int c = 0; c < 20 && !d; c++) begin
            step();
            if (o_Done != 4'b0000) d = 1'b1;
        end
        if (!d) fail_now("rr drain");
        step();

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset in the middle of a writeback
        i_Req      = 4'b0001;
        i_Msg      = 8'h02;
        prev_valid = 1'b0;
        d          = 1'b0;
        for (int c = 0; c < 20 && !d; c++) begin
            step();
            i_Abort = prev_valid ? 4'b0100 : 4'b0000;
            prev_valid = o_BusValid;
            if (o_WbReq != 4'b0000) d = 1'b1;
        end
        if (!d) fail_now("mid-wb entry");
        chk("mid-wb wbreq", o_WbReq, 4'b0100);
        i_Reset = 1'b1;
        i_Abort = 4'b0000;
        #1;
        chk("async reset outputs", {o_Grant, o_BusValid, o_BusMsg, o_BusSrc, o_WbReq, o_Done,
                                    o_Busy, o_Error}, 32'd0);
        #2;
        i_Reset = 1'b0;
        step();
        chk("post-reset grant", o_Grant, 4'b0001);
        i_Req = 4'b0000;
        d = 1'b0;
        for (int c = 0; c < 20 && !d; c++) begin
            step();
            if (o_Done != 4'b0000) d = 1'b1;
        end
        if (!d) fail_now("post-reset drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
Arbitrates the shared snoop bus between N_CPUS per-cache MSI controllers (emitter side) and sequences each bus transaction. It broadcasts the winner's message to all snoopers and collects ABORT from a snooper holding the block in MODIFIED. It then runs that snooper's writeback, re-broadcasts once and signals completion to the requester. Sits between the per-cache emitter/receiver machine pairs and the shared memory bus.

Parameters:
N_CPUS, 4, number of caches/requesters (2..8)
IDX_W, 2, width of requester index, = clog2(N_CPUS)
WB_TIMEOUT, 15, max cycles waited for i_WbDone before declaring error

Ports:
i_Clock  in  1  system clock, rising edge
i_Reset  in  1  asynchronous, active-high reset
i_Req  in  N_CPUS  bus request per cache, level, held until o_Done
i_Msg  in  2*N_CPUS  bus message per cache, [2i+1:2i]: 0 NONE, 1 READ_MISS, 2 WRITE_MISS, 3 INVALIDATE
i_Abort  in  N_CPUS  snooper i holds block MODIFIED, must write back
i_WbDone  in  N_CPUS  snooper i writeback complete, 1-cycle pulse
o_Grant  out  N_CPUS  one-hot grant, held for whole transaction
o_BusValid  out  1  broadcast strobe, 1 cycle
o_BusMsg  out  2  broadcast message
o_BusSrc  out  IDX_W  index of granted requester
o_WbReq  out  N_CPUS  one-hot writeback request to aborting snooper
o_Done  out  N_CPUS  1-cycle completion pulse to requester
o_Busy  out  1  state != IDLE
o_Error  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (async, immediate): state IDLE, all outputs 0, RR pointer 0, retry flag 0, WB counter 0.
- FSM states: IDLE, BCAST, SNOOP, WB, DONE.
- IDLE: if any i_Req, pick the first requester at or after the RR pointer (wrap at N_CPUS-1 -> 0). On that edge go BCAST and latch grant, index and message; o_Grant, o_BusSrc and o_BusMsg are registered and stable until leaving DONE.
- BCAST: o_BusValid=1 for exactly this cycle -> SNOOP.
- SNOOP: sample i_Abort masked by ~o_Grant; a requester's own abort is ignored.
  - No abort -> DONE.
  - Abort with retry flag 0 -> WB targeting the lowest-index aborter.
  - Abort with retry flag 1 -> set o_Error, go DONE.
  - More than one masked abort bit -> set o_Error (MSI violation); still service the lowest index.
- WB: o_WbReq[j]=1; counter increments each cycle.
  - i_WbDone[j] -> clear counter, set retry flag, go BCAST (re-broadcast the same message).
  - Counter reaches WB_TIMEOUT -> set o_Error, go DONE.
  - i_WbDone from a non-target snooper is ignored.
- DONE: o_Done[granted]=1 for one cycle; RR pointer = granted+1 (mod N_CPUS); clear retry flag -> IDLE, where o_Grant clears.
- Message NONE with i_Req: no broadcast; IDLE -> DONE directly (o_Done still pulses).
- Requests are sampled only in IDLE. Deasserting i_Req after grant does not cancel the transaction.
- Latency without abort: grant at edge k, o_BusValid during k..k+1, o_Done during k+2..k+3, IDLE at k+3, next grant no earlier than k+4.
- With abort: +1 WB entry cycle, + writeback wait, +2 for the re-broadcast.
- Reset mid-transaction: everything clears; any pending o_WbReq drops asynchronously.

Decomposition:
- Shared package snoop_pkg holds:
  - message encodings MSG_NONE/READ_MISS/WRITE_MISS/INVALIDATE
  - MSI state encodings INVALID=0, SHARED=1, MODIFIED=2
  - CPU op encodings RM=0, RH=1, WM=2, WH=3
  - arbiter FSM state enum
- Sub-module rr_picker: combinational round-robin select (req vector + pointer -> one-hot + index + valid), reused by the future memory-port arbiter.

Test Plan:
1. Reset: i_Reset pulsed mid-WB (o_WbReq=0100) -> all outputs 0 same cycle; after release, first i_Req=0001 grants cache 0.
2. Single READ_MISS: i_Req=0010, msg=1, no abort -> o_Grant=0010, o_BusValid one cycle with o_BusMsg=1, o_BusSrc=1, o_Done=0010 two cycles after grant, o_Error=0.
3. Round-robin: i_Req=1111 held, each re-asserted after o_Done -> grant order 0001, 0010, 0100, 1000, 0001; spacing exactly 4 cycles.
4. Abort/writeback: cache 0 WRITE_MISS, i_Abort=0100 in SNOOP -> o_WbReq=0100; i_WbDone[2] after 3 cycles -> second o_BusValid with msg=2, no abort -> o_Done=0001, o_Error=0.
5. Self-abort and double abort: requester 1 with i_Abort=0010 -> no WB. Requester 0 with i_Abort=0110 -> o_WbReq=0010, o_Error=1 sticky.
6. Timeout and repeat abort:
   - No i_WbDone -> o_Error=1 after 15 WB cycles, o_Done pulses.
   - Abort again on retry -> o_Error=1, o_Done, no second WB.
